// File: rtl/seq_mult.sv
// Sequential shift-and-add multiplier.
// One partial product is added per clock, so a WIDTH x WIDTH multiply
// takes WIDTH steps plus one cycle for sign correction. Signed operands
// are reduced to magnitudes up front, and the sign is restored at the end.
module seq_mult #(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 signed_mode,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

    state_t               state;
    logic                 neg;
    logic [WIDTH-1:0]     mcand;
    logic [WIDTH-1:0]     mplier;
    logic [2*WIDTH-1:0]   acc;
    logic [CW-1:0]        cnt;

    logic [WIDTH-1:0]     amag;
    logic [WIDTH-1:0]     bmag;
    logic [2*WIDTH-1:0]   addend;

    // Operand magnitudes. -(-2^(W-1)) wraps back to 2^(W-1), which is
    // exactly right when the result is read as an unsigned WIDTH-bit value.
    always_comb begin
        amag   = (signed_mode && a[WIDTH-1]) ? (~a + 1'b1) : a;
        bmag   = (signed_mode && b[WIDTH-1]) ? (~b + 1'b1) : b;
        addend = {{WIDTH{1'b0}}, mcand} << cnt;
    end

    // Control FSM and datapath. All outputs are registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            product <= '0;
            neg     <= 1'b0;
            mcand   <= '0;
            mplier  <= '0;
            acc     <= '0;
            cnt     <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        neg    <= signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
                        mcand  <= amag;
                        mplier <= bmag;
                        acc    <= '0;
                        cnt    <= '0;
                        busy   <= 1'b1;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    // The product of two WIDTH-bit magnitudes always fits in
                    // 2*WIDTH bits, so the top-bit carry is never needed.
                    if (mplier[0])
                        acc <= acc + addend;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 1'b1;
                    if (cnt == CW'(WIDTH - 1))
                        state <= FIN;
                end
                FIN: begin
                    product <= neg ? (~acc + 1'b1) : acc;
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    state   <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_mult.sv
// Self-checking bench for seq_mult: a 4-bit instance for the directed
// cases and an 8-bit instance for the streaming random sweep.
module tb_seq_mult;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // 4-bit instance
    logic       start4 = 1'b0, mode4 = 1'b0;
    logic [3:0] a4 = '0, b4 = '0;
    logic       busy4, done4;
    logic [7:0] prod4;

    // 8-bit instance
    logic        start8 = 1'b0, mode8 = 1'b0;
    logic [7:0]  a8 = '0, b8 = '0;
    logic        busy8, done8;
    logic [15:0] prod8;

    seq_mult #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .signed_mode(mode4),
        .a(a4), .b(b4), .busy(busy4), .done(done4), .product(prod4)
    );

    seq_mult #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .signed_mode(mode8),
        .a(a8), .b(b8), .busy(busy8), .done(done8), .product(prod8)
    );

    int total = 0;
    int bad   = 0;

    logic [7:0]  q4[$];
    logic [15:0] q8[$];

    // Reference multiply: interpret operands per mode, truncate to 2*w bits.
    function automatic longint refmul(input int w, input logic m,
                                      input longint av, input longint bv);
        longint x, y, p;
        x = av;
        y = bv;
        if (m && x[w-1]) x = x - (longint'(1) << w);
        if (m && y[w-1]) y = y - (longint'(1) << w);
        p = x * y;
        return p & ((longint'(1) << (2*w)) - 1);
    endfunction

    task automatic test_reset();
        #1;
        total++;
        if (busy4 !== 1'b0 || done4 !== 1'b0 || prod4 !== 8'h00) begin
            bad++;
            $display("FAIL reset4: busy=%b done=%b product=%h want 0 0 00", busy4, done4, prod4);
        end
        total++;
        if (busy8 !== 1'b0 || done8 !== 1'b0 || prod8 !== 16'h0000) begin
            bad++;
            $display("FAIL reset8: busy=%b done=%b product=%h want 0 0 0000", busy8, done8, prod8);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // One full operation on the 4-bit unit; checks busy, latency, product,
    // pulse width and product hold. Optionally fires a second start mid-run.
    task automatic run4(input string name, input logic m, input logic [3:0] av,
                        input logic [3:0] bv, input bit poke);
        int k, ndone, lat;
        logic [7:0] exp;
        q4.push_back(8'(refmul(4, m, longint'(av), longint'(bv))));
        mode4 = m; a4 = av; b4 = bv; start4 = 1'b1;
        k = 0; ndone = 0; lat = 0;
        while (k < 12) begin
            @(negedge clk);
            k++;
            if (k == 1) begin
                start4 = 1'b0;
                mode4 = ~m; a4 = ~av; b4 = bv + 4'd3;   // latched copies must be used
                total++;
                if (busy4 !== 1'b1) begin
                    bad++;
                    $display("FAIL %s busy: got %b want 1", name, busy4);
                end
            end
            if (poke && k == 2) start4 = 1'b1;
            if (poke && k == 3) start4 = 1'b0;
            if (poke && k >= 1 && k <= 5) begin
                total++;
                if (busy4 !== 1'b1) begin
                    bad++;
                    $display("FAIL %s busy_hold k=%0d: got %b want 1", name, k, busy4);
                end
            end
            if (done4 === 1'b1) begin
                ndone++;
                if (ndone == 1) begin
                    lat = k;
                    exp = q4.pop_front();
                    total++;
                    if (prod4 !== exp) begin
                        bad++;
                        $display("FAIL %s product: got %h want %h", name, prod4, exp);
                    end
                    total++;
                    if (busy4 !== 1'b0) begin
                        bad++;
                        $display("FAIL %s busy_at_done: got %b want 0", name, busy4);
                    end
                end
            end
        end
        total++;
        if (lat !== 6) begin
            bad++;
            $display("FAIL %s latency: got %0d want 6", name, lat);
        end
        total++;
        if (ndone !== 1) begin
            bad++;
            $display("FAIL %s done_count: got %0d want 1", name, ndone);
        end
        if (lat == 0) void'(q4.pop_front());
        total++;
        if (prod4 !== 8'(refmul(4, m, longint'(av), longint'(bv)))) begin
            bad++;
            $display("FAIL %s product_hold: got %h want %h", name, prod4,
                     8'(refmul(4, m, longint'(av), longint'(bv))));
        end
    endtask

    task automatic test_unsigned();
        run4("u15x15", 1'b0, 4'd15, 4'd15, 1'b0);
        total++;
        if (prod4 !== 8'hE1) begin
            bad++;
            $display("FAIL u15x15_const: got %h want e1", prod4);
        end
    endtask

    task automatic test_signed();
        run4("s-8x7", 1'b1, 4'b1000, 4'b0111, 1'b0);
        total++;
        if (prod4 !== 8'hC8) begin
            bad++;
            $display("FAIL s-8x7_const: got %h want c8", prod4);
        end
        run4("s-8x-8", 1'b1, 4'b1000, 4'b1000, 1'b0);
        total++;
        if (prod4 !== 8'h40) begin
            bad++;
            $display("FAIL s-8x-8_const: got %h want 40", prod4);
        end
        run4("s3x-5", 1'b1, 4'd3, 4'b1011, 1'b0);
    endtask

    task automatic test_zero();
        run4("u0x9", 1'b0, 4'd0, 4'd9, 1'b0);
        run4("u9x0", 1'b0, 4'd9, 4'd0, 1'b0);
    endtask

    task automatic test_start_while_busy();
        run4("u6x7_poke", 1'b0, 4'd6, 4'd7, 1'b1);
        total++;
        if (prod4 !== 8'd42) begin
            bad++;
            $display("FAIL poke_result: got %0d want 42", prod4);
        end
    endtask

    task automatic test_abort();
        // Put a known nonzero product in place so the clear is observable.
        run4("u5x5_pre", 1'b0, 4'd5, 4'd5, 1'b0);
        mode4 = 1'b0; a4 = 4'd7; b4 = 4'd7; start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        total++;
        if (busy4 !== 1'b0 || done4 !== 1'b0 || prod4 !== 8'h00) begin
            bad++;
            $display("FAIL abort: busy=%b done=%b product=%h want 0 0 00", busy4, done4, prod4);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            total++;
            if (done4 !== 1'b0) begin
                bad++;
                $display("FAIL abort_no_done cyc=%0d: got %b want 0", i, done4);
            end
        end
        run4("u3x5_after", 1'b0, 4'd3, 4'd5, 1'b0);
        total++;
        if (prod4 !== 8'd15) begin
            bad++;
            $display("FAIL abort_restart: got %0d want 15", prod4);
        end
    endtask

    // start held high continuously with inputs churning every cycle;
    // acceptances occur every WIDTH+2 = 10 cycles starting at the first edge.
    task automatic test_back_to_back();
        int ph, last, ndone;
        logic [15:0] exp;
        ph = 0; last = -1; ndone = 0;
        for (int n = 0; n <= 210; n++) begin
            if (n > 0) begin
                @(negedge clk);
                if (done8 === 1'b1) begin
                    ndone++;
                    if (q8.size() == 0) begin
                        total++; bad++;
                        $display("FAIL b2b_spurious_done n=%0d", n);
                    end else begin
                        exp = q8.pop_front();
                        total++;
                        if (prod8 !== exp) begin
                            bad++;
                            $display("FAIL b2b_product n=%0d: got %h want %h", n, prod8, exp);
                        end
                    end
                    if (last >= 0) begin
                        total++;
                        if (n - last !== 10) begin
                            bad++;
                            $display("FAIL b2b_interval n=%0d: got %0d want 10", n, n - last);
                        end
                    end
                    last = n;
                end
            end
            start8 = (n < 200);
            mode8  = 1'($urandom_range(0, 1));
            a8     = 8'($urandom);
            b8     = 8'($urandom);
            if (n == 20) begin a8 = 8'h80; b8 = 8'h80; end
            if (n == 30) begin a8 = 8'hFF; b8 = 8'hFF; end
            if (n < 200 && ph == 0)
                q8.push_back(16'(refmul(8, mode8, longint'(a8), longint'(b8))));
            ph = (ph + 1) % 10;
        end
        total++;
        if (ndone !== 20) begin
            bad++;
            $display("FAIL b2b_done_count: got %0d want 20", ndone);
        end
        start8 = 1'b0;
    endtask

    initial begin
        test_reset();
        test_unsigned();
        test_signed();
        test_zero();
        test_start_while_busy();
        test_abort();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
